// File: rtl/ex_mem_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_if
// Brief    : EX->MEM result handshake, MEM head view and ID forwarding lookup.
// Revision : 1.0
// ============================================================================
interface ex_mem_skid_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [DATA_W-1:0] ex_wdata_i;
    logic [ADDR_W-1:0] ex_waddr_i;
    logic              ex_write_i;
    logic              flush_i;
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] fwd_raddr_i;
    logic              fwd_hit_o;
    logic [DATA_W-1:0] fwd_data_o;
    logic [1:0]        count_o;

    modport slave (
        input  ex_valid_i, ex_wdata_i, ex_waddr_i, ex_write_i, flush_i,
        input  mem_ready_i, fwd_raddr_i,
        output ex_ready_o, mem_valid_o, mem_wdata_o, mem_waddr_o, mem_write_o,
        output fwd_hit_o, fwd_data_o, count_o
    );

    modport master (
        output ex_valid_i, ex_wdata_i, ex_waddr_i, ex_write_i, flush_i,
        output mem_ready_i, fwd_raddr_i,
        input  ex_ready_o, mem_valid_o, mem_wdata_o, mem_waddr_o, mem_write_o,
        input  fwd_hit_o, fwd_data_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_skid.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid
// Brief    : 2-entry skid buffer on the EX->MEM boundary with ID forwarding.
// Revision : 1.0
// ============================================================================
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire             clk,
    input  wire             rst,
    ex_mem_skid_if.slave    bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state,      w_state_next;
    logic [DATA_W-1:0] r_head_data,  w_head_data_next;
    logic [ADDR_W-1:0] r_head_addr,  w_head_addr_next;
    logic              r_head_write, w_head_write_next;
    logic [DATA_W-1:0] r_tail_data,  w_tail_data_next;
    logic [ADDR_W-1:0] r_tail_addr,  w_tail_addr_next;
    logic              r_tail_write, w_tail_write_next;

    logic w_ready;
    logic w_head_valid;
    logic w_tail_valid;
    logic w_push;
    logic w_pop;
    logic w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Ready comes only from registered state so EX never waits on MEM combinationally.
    assign w_ready      = (r_state != S_TWO);
    assign w_head_valid = (r_state != S_EMPTY);
    assign w_tail_valid = (r_state == S_TWO);
    assign w_push       = bus.ex_valid_i & w_ready;
    assign w_pop        = w_head_valid & bus.mem_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_head_data  <= '0;
            r_head_addr  <= '0;
            r_head_write <= 1'b0;
            r_tail_data  <= '0;
            r_tail_addr  <= '0;
            r_tail_write <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_head_data  <= w_head_data_next;
            r_head_addr  <= w_head_addr_next;
            r_head_write <= w_head_write_next;
            r_tail_data  <= w_tail_data_next;
            r_tail_addr  <= w_tail_addr_next;
            r_tail_write <= w_tail_write_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_head_data_next  = r_head_data;
        w_head_addr_next  = r_head_addr;
        w_head_write_next = r_head_write;
        w_tail_data_next  = r_tail_data;
        w_tail_addr_next  = r_tail_addr;
        w_tail_write_next = r_tail_write;

        // Head fields are zeroed whenever the buffer empties so mem_* reads 0 while invalid.
        if (bus.flush_i) begin
            w_state_next      = S_EMPTY;
            w_head_data_next  = '0;
            w_head_addr_next  = '0;
            w_head_write_next = 1'b0;
            w_tail_data_next  = '0;
            w_tail_addr_next  = '0;
            w_tail_write_next = 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_next      = S_ONE;
                        w_head_data_next  = bus.ex_wdata_i;
                        w_head_addr_next  = bus.ex_waddr_i;
                        w_head_write_next = bus.ex_write_i;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_data_next  = bus.ex_wdata_i;
                        w_head_addr_next  = bus.ex_waddr_i;
                        w_head_write_next = bus.ex_write_i;
                    end else if (w_push) begin
                        w_state_next      = S_TWO;
                        w_tail_data_next  = bus.ex_wdata_i;
                        w_tail_addr_next  = bus.ex_waddr_i;
                        w_tail_write_next = bus.ex_write_i;
                    end else if (w_pop) begin
                        w_state_next      = S_EMPTY;
                        w_head_data_next  = '0;
                        w_head_addr_next  = '0;
                        w_head_write_next = 1'b0;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_state_next      = S_ONE;
                        w_head_data_next  = r_tail_data;
                        w_head_addr_next  = r_tail_addr;
                        w_head_write_next = r_tail_write;
                        w_tail_data_next  = '0;
                        w_tail_addr_next  = '0;
                        w_tail_write_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next      = S_EMPTY;
                    w_head_data_next  = '0;
                    w_head_addr_next  = '0;
                    w_head_write_next = 1'b0;
                end
            endcase
        end
    end

    // Tail is the younger write, so it wins the bypass lookup; r0 is never forwarded.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (bus.fwd_raddr_i != '0) begin
            if (w_tail_valid && r_tail_write && (r_tail_addr == bus.fwd_raddr_i)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_tail_data;
            end else if (w_head_valid && r_head_write && (r_head_addr == bus.fwd_raddr_i)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_head_data;
            end
        end
    end

    assign bus.ex_ready_o  = w_ready;
    assign bus.mem_valid_o = w_head_valid;
    assign bus.mem_wdata_o = r_head_data;
    assign bus.mem_waddr_o = r_head_addr;
    assign bus.mem_write_o = r_head_write;
    assign bus.fwd_hit_o   = w_fwd_hit;
    assign bus.fwd_data_o  = w_fwd_data;
    assign bus.count_o     = r_state;
endmodule
`default_nettype wire
